// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size encoding, control bundle,
// wait-state counter width and the byte-lane helper functions.
package mem_pkg;

    localparam int WAIT_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_e;

    typedef struct packed {
        logic       jump;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] mem_size;
        logic       mem_signed;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    // Reserved size 2'b11 falls into the word branch everywhere.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr;
            SZ_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] addr, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr, 3'b000} +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = addr[0];
            default: m = (addr != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_bytelane.sv
// Word-organised data memory with per-byte write enables and combinational read.
module dm_bytelane #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_pipe.sv
// MIPS memory stage: EX/MEM register, byte-lane data memory and wait-state stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallM,
    input  logic              flushM,
    input  logic              jumpE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemReadE,
    input  logic [1:0]        MemSizeE,
    input  logic              MemSignedE,
    input  logic [1:0]        MemtoRegE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [31:0]       ALUMultOutE,
    input  logic [31:0]       WriteDataE,
    input  logic [31:0]       PCPlus4E,
    output logic              jumpM,
    output logic              RegWriteM,
    output logic [1:0]        MemtoRegM,
    output logic [REG_AW-1:0] WriteRegM,
    output logic [31:0]       ALUMultOutM,
    output logic [31:0]       ReadDataM,
    output logic [31:0]       PCPlus8M,
    output logic              MemBusyM,
    output logic              MisalignM
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    ctrl_t             ctrl_d, ctrl_q, ctrl_e_s;
    logic [REG_AW-1:0] wreg_d, wreg_q;
    logic [31:0]       alu_d, alu_q, wdata_d, wdata_q, pc4_d, pc4_q;
    logic [WAIT_W-1:0] wcnt_d, wcnt_q;
    logic              done_d, done_q;
    wait_state_e       state_s;
    logic              busy_s, load_s, flush_s, mis_e_s, mis_m_s, store_en_s;
    logic [3:0]        we_s;
    logic [31:0]       rdata_s;

    assign ctrl_e_s = '{jump: jumpE, reg_write: RegWriteE, mem_write: MemWriteE,
                        mem_read: MemReadE, mem_size: MemSizeE, mem_signed: MemSignedE,
                        mem_to_reg: MemtoRegE};

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_e_s = (MemReadE | MemWriteE) & misaligned(MemSizeE, ALUMultOutE[1:0]);
    assign mis_m_s = (ctrl_q.mem_read | ctrl_q.mem_write) & misaligned(ctrl_q.mem_size, alu_q[1:0]);
`else
    assign mis_e_s = 1'b0;
    assign mis_m_s = 1'b0;
`endif

    // State register: wait counter plus pipeline register and store-done flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt_q  <= '0;
            ctrl_q  <= '0;
            wreg_q  <= '0;
            alu_q   <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            done_q  <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            ctrl_q  <= ctrl_d;
            wreg_q  <= wreg_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            pc4_q   <= pc4_d;
            done_q  <= done_d;
        end
    end

    // Next wait count: count down while busy, arm on capture of an aligned access.
    always_comb begin
        if (busy_s) begin
            wcnt_d = wcnt_q - 4'd1;
        end else if (load_s && (MemReadE || MemWriteE) && !mis_e_s) begin
            wcnt_d = WAIT_LOAD;
        end else begin
            wcnt_d = '0;
        end
    end

    // Decode: busy freezes the register; flush outranks stall.
    always_comb begin
        state_s = (wcnt_q != '0) ? ST_WAIT : ST_IDLE;
        busy_s  = (state_s == ST_WAIT);
        if (busy_s) begin
            load_s  = 1'b0;
            flush_s = 1'b0;
        end else if (flushM) begin
            load_s  = 1'b0;
            flush_s = 1'b1;
        end else if (!stallM) begin
            load_s  = 1'b1;
            flush_s = 1'b0;
        end else begin
            load_s  = 1'b0;
            flush_s = 1'b0;
        end
    end

    // Pipeline register next values; a bubble clears controls only.
    always_comb begin
        ctrl_d  = ctrl_q;
        wreg_d  = wreg_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        pc4_d   = pc4_q;
        if (flush_s) begin
            ctrl_d = '0;
        end else if (load_s) begin
            ctrl_d  = ctrl_e_s;
            wreg_d  = WriteRegE;
            alu_d   = ALUMultOutE;
            wdata_d = WriteDataE;
            pc4_d   = PCPlus4E;
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // A stalled store must commit once; done_q blocks repeats until a new op arrives.
    always_comb begin
        store_en_s = rst & ctrl_q.mem_write & ~busy_s & ~done_q & ~mis_m_s;
        we_s       = store_en_s ? lane_mask(ctrl_q.mem_size, alu_q[1:0]) : 4'b0000;
        if (load_s || flush_s) begin
            done_d = 1'b0;
        end else if (store_en_s) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
    end

    dm_bytelane #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dm (
        .clk   (clk),
        .we    (we_s),
        .addr  (alu_q[AW+1:2]),
        .wdata (store_replicate(ctrl_q.mem_size, wdata_q)),
        .rdata (rdata_s)
    );

    assign jumpM       = ctrl_q.jump;
    assign RegWriteM   = ctrl_q.reg_write & ~mis_m_s;
    assign MemtoRegM   = ctrl_q.mem_to_reg;
    assign WriteRegM   = wreg_q;
    assign ALUMultOutM = alu_q;
    assign PCPlus8M    = pc4_q + 32'd4;
    assign MemBusyM    = busy_s;
    assign MisalignM   = mis_m_s;
    assign ReadDataM   = ctrl_q.mem_read
                       ? load_extend(ctrl_q.mem_size, ctrl_q.mem_signed, alu_q[1:0], rdata_s)
                       : 32'h0000_0000;

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
Parametrised successor to the MIPS memory stage.
- Holds the EX/MEM pipeline register, with stall and flush.
- Owns a byte-lane data memory supporting sb/sh/sw stores and lb/lbu/lh/lhu/lw loads.
- Models a slow memory with a configurable wait-state counter and raises MemBusyM so the hazard unit stalls the front of the pipe.
- Sits between the execute stage and the writeback stage.

Parameters:
DEPTH, 256, data memory depth in 32-bit words; power of 2, minimum 4.
WAIT_STATES, 0, extra cycles per memory access; range 0..15.
REG_AW, 5, register-file address width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset; synchronous, active-low (state clears on a posedge clk while rst=0).
stallM  in  1  hold the M register.
flushM  in  1  load a bubble into the M register.
jumpE, RegWriteE, MemWriteE, MemReadE  in  1 each  execute-stage controls.
MemSizeE  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
MemSignedE  in  1  sign-extend sub-word loads.
MemtoRegE  in  2  writeback mux select.
WriteRegE  in  REG_AW  destination register.
ALUMultOutE, WriteDataE, PCPlus4E  in  32 each  address/result, store data, PC+4.
jumpM, RegWriteM  out  1 each  registered controls.
MemtoRegM  out  2  registered.
WriteRegM  out  REG_AW  registered.
ALUMultOutM  out  32  registered.
ReadDataM  out  32  formatted load data; 0 when MemReadM=0.
PCPlus8M  out  32  PCPlus4M+4, mod 2^32.
MemBusyM  out  1  access in progress; combinational, =(wcnt!=0).
MisalignM  out  1  misaligned access flag (see Optional Feature).

Behaviour:
- Reset (rst=0 at posedge): all M registers, including internal MemWriteM/MemReadM/MemSizeM/MemSignedM/WriteDataM/PCPlus4M, clear to 0; wcnt=0. Every output is 0 except PCPlus8M=4. Memory contents are not reset.
- Capture edge (MemBusyM=0):
  - flushM=1: control regs cleared (bubble); flushM has priority over stallM.
  - else stallM=1: hold all registers.
  - else: load all E inputs.
- Wait counter (wcnt, 4 bits):
  - On capture of an op with MemReadE|MemWriteE and WAIT_STATES>0: wcnt<=WAIT_STATES.
  - While wcnt!=0: wcnt decrements each cycle, M register held, stallM/flushM ignored.
- States: IDLE (wcnt=0) and WAIT (wcnt!=0). WAIT returns to IDLE after exactly WAIT_STATES cycles.
- Store commit: a store is written at the posedge ending the first cycle in which MemWriteM=1 and MemBusyM=0; one write only.
  - Byte lanes from ALUMultOutM[1:0]: byte writes lane addr[1:0]; half writes lanes {addr[1],x}; word writes all lanes.
  - Store data is taken from the low bits of WriteDataM, replicated to the selected lanes.
- Load read: combinational from the word at ALUMultOutM. ReadDataM is valid whenever MemBusyM=0.
  - Byte/half lanes are selected by address, then zero- or sign-extended per MemSignedM.
- Address wrap: word index = ALUMultOutM[log2(DEPTH)+1:2]; upper bits are ignored.
- Latency: with WAIT_STATES=0, ReadDataM is valid in the cycle after capture. With WAIT_STATES=N, it is valid N cycles later.
- Reset during WAIT: wcnt cleared; a pending store is NOT committed.
- Back-to-back stores: each store commits separately. A load immediately following a store to the same word sees the new data.

Optional Feature:
Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, sets MisalignM=1 (combinational from the M regs).
  - The store is suppressed and RegWriteM is forced to 0.
  - No wait states are inserted; wcnt is not loaded for that op.
- Undefined:
  - MisalignM is tied 0.
  - Low address bits are ignored for the access width (half uses addr[1]; word uses the aligned word).

Decomposition:
- Shared package mem_pkg:
  - MemSize encoding constants: SZ_BYTE, SZ_HALF, SZ_WORD.
  - Lane-mask function.
  - Load-extend function.
  - WAIT_W=4.
- One sub-module, dm_bytelane: a DEPTH×32 array with a 4-bit write-enable and combinational read.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> all outputs 0, PCPlus8M=4, MemBusyM=0.
- sw 0xDEADBEEF @0x10, then lb @0x13 signed -> ReadDataM=0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 signed -> 0xFFFFDEAD.
- sb 0x5A @0x11 over 0xDEADBEEF -> following lw @0x10 reads 0xDEAD5AEF.
- WAIT_STATES=3, lw @0x20: MemBusyM high exactly 3 cycles. Assert stallM=0 and flushM=1 during busy -> M register unchanged. ReadDataM valid on the 4th cycle. Next capture only after busy drops.
- WAIT_STATES=2, sw @0x30 with rst pulsed low mid-WAIT -> later lw @0x30 returns the old value.
- MEM_MISALIGN_TRAP_EN defined, lw @0x22 with RegWriteE=1 -> MisalignM=1, RegWriteM=0, no busy, memory unchanged. Undefined -> MisalignM=0, lw reads word 0x20.
